// File: rtl/cluster_pkg.sv
// Shared constants and types for the cluster frame encoder and its sub-blocks.
package cluster_pkg;
  localparam int MXSEGS     = 24;
  localparam int SEGSIZE    = 64;
  localparam int MXCLUSTERS = 8;
  localparam int ADRB       = 11;
  localparam int IDXB       = 6;
  localparam int SEGB       = 5;

  localparam logic [ADRB-1:0] INVALID_ADR = 11'h7FF;

  typedef logic [ADRB-1:0] cluster_adr_t;
endpackage

// File: rtl/lsb_encoder64.sv
// Combinational 64-bit lowest-set-bit encoder; idx is 0 when no bit is set.
module lsb_encoder64 (
  input  logic [63:0] vec,
  output logic [5:0]  idx,
  output logic        any
);
  always_comb begin
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) idx = 6'(i);
    end
  end

  assign any = |vec;
endmodule

// File: rtl/cluster_frame_encoder.sv
// Three-stage LSB priority encoder over the truncated VPF vector, followed by a
// collector that packs the unique addresses of one 8-sample window into a frame.
module cluster_frame_encoder
  import cluster_pkg::*;
(
  input  logic                          clock,
  input  logic                          global_reset,
  input  logic                          frame_start,
  input  logic [MXSEGS*SEGSIZE-1:0]     vpfs_in,
  output logic [MXCLUSTERS*ADRB-1:0]    adr_out,
  output logic [MXCLUSTERS-1:0]         adr_valid,
  output logic [3:0]                    cluster_count,
  output logic                          frame_valid
);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Sample index/live generation on the input side; travels with the data.
  logic [2:0] cnt_q;
  logic       live_q;
  logic [2:0] in_idx;
  logic       in_live;

  assign in_idx  = frame_start ? 3'd0 : ((cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1);
  assign in_live = frame_start | (live_q & (cnt_q != 3'd7));

  logic [IDXB-1:0]   enc_idx [MXSEGS];
  logic [MXSEGS-1:0] enc_any;

  for (genvar g = 0; g < MXSEGS; g++) begin : g_enc
    lsb_encoder64 u_enc (
      .vec (vpfs_in[g*SEGSIZE +: SEGSIZE]),
      .idx (enc_idx[g]),
      .any (enc_any[g])
    );
  end

  logic [IDXB-1:0]   s1_idx [MXSEGS];
  logic [MXSEGS-1:0] s1_any;
  logic              s1_start, s1_live;
  logic [2:0]        s1_tag;

  logic [SEGB-1:0]   sel_seg;
  logic [IDXB-1:0]   sel_idx;

  always_comb begin
    sel_seg = '0;
    sel_idx = '0;
    for (int i = MXSEGS - 1; i >= 0; i--) begin
      if (s1_any[i]) begin
        sel_seg = SEGB'(i);
        sel_idx = s1_idx[i];
      end
    end
  end

  logic [SEGB-1:0]   s2_seg;
  logic [IDXB-1:0]   s2_idx;
  logic              s2_hit, s2_start, s2_live;
  logic [2:0]        s2_tag;

  cluster_adr_t      s3_adr;
  logic              s3_hit, s3_start, s3_live;
  logic [2:0]        s3_tag;

  always_ff @(posedge clock) begin
    if (global_reset) begin
      cnt_q    <= '0;
      live_q   <= 1'b0;
      s1_any   <= '0;
      s1_start <= 1'b0;
      s1_live  <= 1'b0;
      s1_tag   <= '0;
      s2_seg   <= '0;
      s2_idx   <= '0;
      s2_hit   <= 1'b0;
      s2_start <= 1'b0;
      s2_live  <= 1'b0;
      s2_tag   <= '0;
      s3_adr   <= INVALID_ADR;
      s3_hit   <= 1'b0;
      s3_start <= 1'b0;
      s3_live  <= 1'b0;
      s3_tag   <= '0;
    end else begin
      cnt_q    <= in_idx;
      live_q   <= in_live;
      s1_any   <= enc_any;
      s1_start <= frame_start;
      s1_live  <= in_live;
      s1_tag   <= in_idx;
      s2_seg   <= sel_seg;
      s2_idx   <= sel_idx;
      s2_hit   <= |s1_any;
      s2_start <= s1_start;
      s2_live  <= s1_live;
      s2_tag   <= s1_tag;
      // seg*64 + idx is just the concatenation of the two fields.
      s3_adr   <= s2_hit ? {s2_seg, s2_idx} : INVALID_ADR;
      s3_hit   <= s2_hit;
      s3_start <= s2_start;
      s3_live  <= s2_live;
      s3_tag   <= s2_tag;
    end
  end

  // Index array is data only; no reset needed since s1_any gates its use.
  always_ff @(posedge clock) begin
    s1_idx <= enc_idx;
  end

  logic [0:0]   state_q, state_d;
  cluster_adr_t acc_q [MXCLUSTERS];
  cluster_adr_t acc_d [MXCLUSTERS];
  logic [3:0]   acc_cnt_q, cnt_d;
  cluster_adr_t last_q, last_d;
  logic         take, latch;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = acc_cnt_q;
    last_d  = last_q;
    take    = 1'b0;
    latch   = 1'b0;
    if (s3_live) begin
      if (s3_start) begin
        // A start always opens a fresh frame, discarding any partial one.
        state_d = ST_COLLECT;
        cnt_d   = '0;
        for (int i = 0; i < MXCLUSTERS; i++) acc_d[i] = INVALID_ADR;
        take    = 1'b1;
      end else if (state_q == ST_COLLECT) begin
        take = 1'b1;
      end
    end
    if (take) begin
      if (s3_hit && (cnt_d < 4'd8) && ((cnt_d == 4'd0) || (s3_adr != last_q))) begin
        acc_d[cnt_d[2:0]] = s3_adr;
        cnt_d             = cnt_d + 4'd1;
        last_d            = s3_adr;
      end
      if (s3_tag == 3'd7) begin
        latch   = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_q       <= ST_IDLE;
      acc_cnt_q     <= '0;
      last_q        <= INVALID_ADR;
      frame_valid   <= 1'b0;
      adr_valid     <= '0;
      cluster_count <= '0;
      for (int i = 0; i < MXCLUSTERS; i++) begin
        acc_q[i]                  <= INVALID_ADR;
        adr_out[i*ADRB +: ADRB]   <= INVALID_ADR;
      end
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      frame_valid <= latch;
      if (latch) begin
        cluster_count <= cnt_d;
        acc_cnt_q     <= '0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
          adr_out[i*ADRB +: ADRB] <= acc_d[i];
          adr_valid[i]            <= (4'(i) < cnt_d);
          acc_q[i]                <= INVALID_ADR;
        end
      end else begin
        acc_cnt_q <= cnt_d;
        acc_q     <= acc_d;
      end
    end
  end
endmodule

// File: tb/tb_cluster_frame_encoder.sv
// Directed bench for cluster_frame_encoder: hand-computed frames checked with immediate assertions.
module tb_cluster_frame_encoder;
  import cluster_pkg::*;

  logic          clock = 1'b0;
  logic          global_reset;
  logic          frame_start;
  logic [1535:0] vpfs_in;
  logic [87:0]   adr_out;
  logic [7:0]    adr_valid;
  logic [3:0]    cluster_count;
  logic          frame_valid;

  cluster_frame_encoder dut (
    .clock         (clock),
    .global_reset  (global_reset),
    .frame_start   (frame_start),
    .vpfs_in       (vpfs_in),
    .adr_out       (adr_out),
    .adr_valid     (adr_valid),
    .cluster_count (cluster_count),
    .frame_valid   (frame_valid)
  );

  always #5 clock = ~clock;

  logic [1535:0] vecs [8];
  logic [10:0]   exp_slot [8];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            drive_fv_count;
  int            cap_j;
  logic [87:0]   cap_adr;
  logic [7:0]    cap_valid;
  logic [3:0]    cap_cnt;
  logic [1535:0] v;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [87:0] exp_adr();
    logic [87:0] r;
    for (int i = 0; i < 8; i++) r[i*11 +: 11] = exp_slot[i];
    return r;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 8; i++) exp_slot[i] = 11'h7FF;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_frame();
    drive_fv_count = 0;
    cap_j          = -1;
    for (int j = 0; j < 8; j++) begin
      frame_start = (j == 0);
      vpfs_in     = vecs[j];
      step();
      if (frame_valid) begin
        drive_fv_count++;
        cap_j     = j;
        cap_adr   = adr_out;
        cap_valid = adr_valid;
        cap_cnt   = cluster_count;
      end
    end
    frame_start = 1'b0;
    vpfs_in     = '0;
  endtask

  // Called at cycle T+8 of a frame started at T; frame_valid is due at T+11.
  task automatic wait_frame(input string tag, input logic [7:0] ev, input logic [3:0] ec);
    int k;
    k = 0;
    while (!frame_valid && k < 20) begin
      step();
      k++;
    end
    check({tag, "_latency"}, k, 3);
    check({tag, "_adr"}, adr_out, exp_adr());
    check({tag, "_valid"}, adr_valid, ev);
    check({tag, "_count"}, cluster_count, ec);
    step();
    check({tag, "_strobe_low"}, frame_valid, 1'b0);
    check({tag, "_hold"}, adr_out, exp_adr());
  endtask

  initial begin
    int seen;
    global_reset = 1'b1;
    frame_start  = 1'b0;
    vpfs_in      = '0;
    repeat (3) step();
    global_reset = 1'b0;
    step();
    clear_exp();
    check("reset_adr", adr_out, exp_adr());
    check("reset_valid", adr_valid, 8'h00);
    check("reset_count", cluster_count, 4'd0);
    check("reset_fv", frame_valid, 1'b0);

    // Single bit 5 held for the whole window.
    v = '0; v[5] = 1'b1;
    for (int j = 0; j < 8; j++) vecs[j] = v;
    drive_frame();
    clear_exp(); exp_slot[0] = 11'd5;
    wait_frame("bit5", 8'h01, 4'd1);

    // Truncation of {0,1535}.
    v = '0; v[0] = 1'b1; v[1535] = 1'b1; vecs[0] = v;
    v = '0; v[1535] = 1'b1; vecs[1] = v; vecs[2] = v;
    for (int j = 3; j < 8; j++) vecs[j] = '0;
    drive_frame();
    clear_exp(); exp_slot[0] = 11'd0; exp_slot[1] = 11'd1535;
    wait_frame("edges", 8'h03, 4'd2);

    // Ten bits 100..1000 truncated one per cycle.
    for (int j = 0; j < 8; j++) begin
      v = '0;
      for (int b = j + 1; b <= 10; b++) v[100*b] = 1'b1;
      vecs[j] = v;
    end
    drive_frame();
    clear_exp();
    exp_slot[0] = 11'd100; exp_slot[1] = 11'd200; exp_slot[2] = 11'd300; exp_slot[3] = 11'd400;
    exp_slot[4] = 11'd500; exp_slot[5] = 11'd600; exp_slot[6] = 11'd700; exp_slot[7] = 11'd800;
    wait_frame("ten", 8'hFF, 4'd8);

    // All-zero frame still strobes.
    for (int j = 0; j < 8; j++) vecs[j] = '0;
    drive_frame();
    clear_exp();
    wait_frame("zero", 8'h00, 4'd0);

    // Duplicate suppression: 64,64,130,130,...
    v = '0; v[64] = 1'b1; vecs[0] = v; vecs[1] = v;
    v = '0; v[130] = 1'b1;
    for (int j = 2; j < 8; j++) vecs[j] = v;
    drive_frame();
    clear_exp(); exp_slot[0] = 11'd64; exp_slot[1] = 11'd130;
    wait_frame("dup", 8'h03, 4'd2);

    // Abort: a second start 4 cycles after the first.
    v = '0; v[5] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      frame_start = (j == 0);
      vpfs_in     = v;
      step();
    end
    v = '0; v[7] = 1'b1;
    for (int j = 0; j < 8; j++) vecs[j] = v;
    drive_frame();
    check("abort_no_early_fv", drive_fv_count, 0);
    clear_exp(); exp_slot[0] = 11'd7;
    wait_frame("abort", 8'h01, 4'd1);

    // Back-to-back frames: A's strobe lands 3 cycles into B.
    v = '0; v[5] = 1'b1;
    for (int j = 0; j < 8; j++) vecs[j] = v;
    drive_frame();
    v = '0; v[200] = 1'b1;
    for (int j = 0; j < 8; j++) vecs[j] = v;
    drive_frame();
    clear_exp(); exp_slot[0] = 11'd5;
    check("b2b_a_count_strobes", drive_fv_count, 1);
    check("b2b_a_position", cap_j, 2);
    check("b2b_a_adr", cap_adr, exp_adr());
    check("b2b_a_valid", cap_valid, 8'h01);
    check("b2b_a_count", cap_cnt, 4'd1);
    clear_exp(); exp_slot[0] = 11'd200;
    wait_frame("b2b_b", 8'h01, 4'd1);

    // Reset mid-frame.
    v = '0; v[5] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      frame_start = (j == 0);
      vpfs_in     = v;
      step();
    end
    frame_start  = 1'b0;
    global_reset = 1'b1;
    step();
    global_reset = 1'b0;
    seen = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      if (frame_valid) seen++;
    end
    check("midreset_no_fv", seen, 0);
    clear_exp();
    check("midreset_adr", adr_out, exp_adr());
    check("midreset_valid", adr_valid, 8'h00);
    check("midreset_count", cluster_count, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
